// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: two packed request lanes
// plus a shared response bus with one valid bit per requester.
interface alu_arbiter_if #(
    parameter int Nsize = 3
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*Nsize-1:0] req_a;
    logic [2*Nsize-1:0] req_b;
    logic [5:0]         req_aop;
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [Nsize-1:0]   resp_result;
    logic               resp_err;

    modport master (
        output req_valid, req_a, req_b, req_aop, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_aop, resp_ready,
        output req_ready, resp_valid, resp_result, resp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// operands are registered before the ALU and the result is registered after it.
module alu_arbiter #(
    parameter int Nsize = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic [Nsize-1:0] alu_a,
    output logic [Nsize-1:0] alu_b,
    output logic [2:0]       alu_aop,
    input  logic [Nsize-1:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [Nsize-1:0] alu_a_q;
    logic [Nsize-1:0] alu_b_q;
    logic [2:0]       alu_aop_q;
    logic [1:0]       resp_valid_q;
    logic [Nsize-1:0] resp_result_q;
    logic             resp_err_q;

    logic             grant_valid_s;
    logic             grant_idx_s;
    logic [1:0]       req_ready_s;
    logic [Nsize-1:0] sel_a_s;
    logic [Nsize-1:0] sel_b_s;
    logic [2:0]       sel_aop_s;

    // Grant decision and operand selection; only IDLE may accept a request.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        req_ready_s   = 2'b00;
        if (state_q == S_IDLE) begin
            case (bus.req_valid)
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = 1'b0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = 1'b1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = ~last_grant_q;
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_idx_s   = 1'b0;
                end
            endcase
            if (grant_valid_s) begin
                req_ready_s = grant_idx_s ? 2'b10 : 2'b01;
            end else begin
                req_ready_s = 2'b00;
            end
        end else begin
            req_ready_s = 2'b00;
        end
        sel_a_s   = grant_idx_s ? bus.req_a[Nsize +: Nsize] : bus.req_a[0 +: Nsize];
        sel_b_s   = grant_idx_s ? bus.req_b[Nsize +: Nsize] : bus.req_b[0 +: Nsize];
        sel_aop_s = grant_idx_s ? bus.req_aop[3 +: 3] : bus.req_aop[0 +: 3];
    end

    // Request/execute/respond sequencing with all outputs held in registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            alu_a_q       <= {Nsize{1'b0}};
            alu_b_q       <= {Nsize{1'b0}};
            alu_aop_q     <= 3'b000;
            resp_valid_q  <= 2'b00;
            resp_result_q <= {Nsize{1'b0}};
            resp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_valid_s) begin
                        alu_a_q      <= sel_a_s;
                        alu_b_q      <= sel_b_s;
                        alu_aop_q    <= sel_aop_s;
                        owner_q      <= grant_idx_s;
                        last_grant_q <= grant_idx_s;
                        state_q      <= S_EXEC;
                    end else begin
                        state_q      <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    // Reserved opcode is flagged and its ALU output discarded.
                    if (alu_aop_q == 3'b111) begin
                        resp_result_q <= {Nsize{1'b0}};
                        resp_err_q    <= 1'b1;
                    end else begin
                        resp_result_q <= alu_result;
                        resp_err_q    <= 1'b0;
                    end
                    resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready[owner_q]) begin
                        resp_valid_q <= 2'b00;
                        state_q      <= S_IDLE;
                    end else begin
                        state_q      <= S_RESP;
                    end
                end
                default: begin
                    resp_valid_q <= 2'b00;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = rst_n ? req_ready_s : 2'b00;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_err    = resp_err_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign alu_aop         = alu_aop_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table of single ops, contention, backpressure
// and reset-abort sequences, checked through an expected-response queue.
module tb_alu_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_aop;
    logic [N-1:0] alu_result;

    alu_arbiter_if #(.Nsize(N)) bus ();

    alu_arbiter #(.Nsize(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_aop    (alu_aop),
        .alu_result (alu_result)
    );

    // Stand-in ALU; reserved opcode returns a nonzero pattern so forcing to zero is visible.
    function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
        case (op)
            3'b000:  return a;
            3'b001:  return ~a;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a | b;
            3'b101:  return a & b;
            3'b110:  return (a < b) ? 4'd1 : 4'd0;
            default: return 4'hF;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_aop);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         r;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       err;
    } vec_t;

    typedef struct {
        logic [1:0] vld;
        logic [3:0] res;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         hs_cyc = 0;
    logic [1:0] last_hs;
    logic [1:0] prev_rv = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample handshakes/completions just after inputs settle, then advance.
    task automatic tick();
        logic [1:0] rs;
        exp_t       e;
        #1;
        last_hs = bus.req_valid & bus.req_ready;
        rs      = bus.resp_valid & bus.resp_ready;
        if (last_hs != 2'b00) hs_cyc = cyc;
        if (bus.resp_valid != 2'b00 && prev_rv == 2'b00) chk("latency", cyc - hs_cyc, 2);
        prev_rv = bus.resp_valid;
        if (rs != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {30'd0, bus.resp_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_valid", bus.resp_valid, e.vld);
                chk("resp_result", bus.resp_result, e.res);
                chk("resp_err", bus.resp_err, e.err);
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_a[v.r*N +: N] = v.a;
        bus.req_b[v.r*N +: N] = v.b;
        bus.req_aop[v.r*3 +: 3] = v.op;
    endtask

    // Single request from an idle block, response accepted immediately.
    task automatic run_op(input vec_t v);
        logic [1:0] oh;
        oh = (v.r == 1) ? 2'b10 : 2'b01;
        drive_req(v);
        bus.req_valid  = oh;
        bus.resp_ready = 2'b11;
        exp_q.push_back('{oh, v.res, v.err});
        tick();
        chk("grant", last_hs, oh);
        bus.req_valid = 2'b00;
        chk("alu_a", alu_a, v.a);
        chk("alu_b", alu_b, v.b);
        chk("alu_aop", alu_aop, v.op);
        tick();
        tick();
    endtask

    vec_t vecs[11];
    vec_t cont[4];
    vec_t v;
    int   gord[4];
    int   gcy[4];
    int   gcount;
    int   idx[2];

    initial begin
        vecs[0]  = '{0, 4'd3,  4'd5, 3'b010, 4'h8, 1'b0};
        vecs[1]  = '{1, 4'd2,  4'd5, 3'b011, 4'hD, 1'b0};
        vecs[2]  = '{0, 4'd9,  4'd1, 3'b000, 4'h9, 1'b0};
        vecs[3]  = '{1, 4'd5,  4'd0, 3'b001, 4'hA, 1'b0};
        vecs[4]  = '{0, 4'hA,  4'h5, 3'b100, 4'hF, 1'b0};
        vecs[5]  = '{1, 4'hC,  4'h6, 3'b101, 4'h4, 1'b0};
        vecs[6]  = '{0, 4'd2,  4'd7, 3'b110, 4'h1, 1'b0};
        vecs[7]  = '{1, 4'd7,  4'd2, 3'b110, 4'h0, 1'b0};
        vecs[8]  = '{0, 4'd7,  4'd1, 3'b111, 4'h0, 1'b1};
        vecs[9]  = '{0, 4'hF,  4'h1, 3'b010, 4'h0, 1'b0};
        vecs[10] = '{1, 4'hF,  4'hF, 3'b010, 4'hE, 1'b0};
        cont[0]  = '{0, 4'd1,  4'd1, 3'b010, 4'h2, 1'b0};
        cont[1]  = '{1, 4'd0,  4'd1, 3'b011, 4'hF, 1'b0};
        cont[2]  = '{0, 4'd3,  4'd4, 3'b100, 4'h7, 1'b0};
        cont[3]  = '{1, 4'hF,  4'h3, 3'b101, 4'h3, 1'b0};

        rst_n          = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_a      = 8'h35;
        bus.req_b      = 8'h26;
        bus.req_aop    = 6'b010_011;
        bus.resp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_resp_result", bus.resp_result, 4'h0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_alu_a", alu_a, 4'h0);
        chk("rst_alu_b", alu_b, 4'h0);
        chk("rst_alu_aop", alu_aop, 3'b000);
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // Contention: both valid throughout, last grant was requester 1.
        gcount = 0;
        idx[0] = 0;
        idx[1] = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back('{(k % 2 == 1) ? 2'b10 : 2'b01, cont[k].res, 1'b0});
        drive_req(cont[0]);
        drive_req(cont[1]);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        for (int t = 0; t < 40; t++) begin
            if (gcount == 4 && exp_q.size() == 0) break;
            tick();
            if (last_hs != 2'b00 && gcount < 4) begin
                int r;
                r = last_hs[1] ? 1 : 0;
                gord[gcount] = r;
                gcy[gcount]  = hs_cyc;
                gcount++;
                idx[r]++;
                if (idx[r] >= 2) bus.req_valid[r] = 1'b0;
                else drive_req(cont[2*idx[r] + r]);
            end
        end
        chk("cont_grants", gcount, 4);
        for (int k = 0; k < 4; k++) chk("cont_order", gord[k], k % 2);
        for (int k = 1; k < 4; k++) chk("cont_spacing", gcy[k] - gcy[k-1], 3);
        bus.req_valid = 2'b00;

        // Backpressure on requester 1 with requester 0 waiting and non-owner ready ignored.
        v = '{1, 4'd4, 4'd5, 3'b010, 4'h9, 1'b0};
        drive_req(v);
        bus.req_valid  = 2'b10;
        bus.resp_ready = 2'b00;
        exp_q.push_back('{2'b10, 4'h9, 1'b0});
        tick();
        chk("bp_grant", last_hs, 2'b10);
        bus.req_valid = 2'b01;
        tick();
        tick();
        for (int t = 0; t < 10; t++) begin
            bus.resp_ready = (t % 2 == 1) ? 2'b01 : 2'b00;
            tick();
            chk("bp_resp_valid", bus.resp_valid, 2'b10);
            chk("bp_resp_result", bus.resp_result, 4'h9);
            chk("bp_req_ready", bus.req_ready, 2'b00);
            chk("bp_alu_a", alu_a, 4'd4);
        end
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b10;
        tick();
        chk("bp_release", bus.resp_valid, 2'b00);
        chk("bp_drained", exp_q.size(), 0);

        // Reset during EXEC discards the request; requester 1 then wins at once.
        v = '{0, 4'd1, 4'd2, 3'b010, 4'h3, 1'b0};
        drive_req(v);
        bus.req_valid  = 2'b01;
        bus.resp_ready = 2'b11;
        tick();
        chk("mid_grant", last_hs, 2'b01);
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("mid_req_ready", bus.req_ready, 2'b00);
        chk("mid_resp_valid", bus.resp_valid, 2'b00);
        chk("mid_alu_a", alu_a, 4'h0);
        chk("mid_alu_aop", alu_aop, 3'b000);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        run_op('{1, 4'd6, 4'd1, 3'b010, 4'h7, 1'b0});
        for (int t = 0; t < 4; t++) tick();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
